// File: rtl/jtframe_rom_arb.sv
// Round-robin arbiter that shares one SDRAM read channel among N ROM fetchers.
// Optional JTFRAME_ARB_FIXPRIO_EN: slot 0 (CPU ROM) gets fixed top priority.
module jtframe_rom_arb #(
    parameter int N  = 4,
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic            loop_rst,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] addr,
    output logic [N-1:0]    ok,
    output logic [DW-1:0]   dout,
    output logic            busy,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    input  logic [DW-1:0]   data_read,
    output logic            refresh_en
);
    localparam int IW = $clog2(N);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_WAIT_RDY = 2'd2
    } state_t;

    state_t        state_r;
    logic [IW-1:0] gnt_r;
    logic [IW-1:0] last_r;

    logic [AW-1:0] addr_a_s [N];
    logic [N-1:0]  rr_req_s;
    logic [IW-1:0] rr_pick_s;
    logic          rr_found_s;
    logic [IW:0]   sum_s;
    logic [IW:0]   idx_s;
    logic [IW-1:0] pick_s;
    logic [IW-1:0] next_last_s;
    logic          found_s;
    logic          grant_s;

    for (genvar i = 0; i < N; i++) begin : g_addr
        assign addr_a_s[i] = addr[i*AW +: AW];
    end

    // Round-robin search: walk slots last+N down to last+1 so the nearest set bit wins.
    always_comb begin
        rr_pick_s  = {IW{1'b0}};
        rr_found_s = 1'b0;
        sum_s      = {(IW+1){1'b0}};
        idx_s      = {(IW+1){1'b0}};
        for (int k = N; k >= 1; k--) begin
            sum_s      = {1'b0, last_r} + (IW+1)'(k);
            idx_s      = (sum_s >= (IW+1)'(N)) ? (sum_s - (IW+1)'(N)) : sum_s;
            rr_pick_s  = rr_req_s[idx_s[IW-1:0]] ? idx_s[IW-1:0] : rr_pick_s;
            rr_found_s = rr_found_s | rr_req_s[idx_s[IW-1:0]];
        end
    end

`ifdef JTFRAME_ARB_FIXPRIO_EN
    // Slot 0 bypasses the pointer; the pointer only tracks the other slots.
    assign rr_req_s    = {req[N-1:1], 1'b0};
    assign found_s     = req[0] | rr_found_s;
    assign pick_s      = req[0] ? {IW{1'b0}} : rr_pick_s;
    assign next_last_s = req[0] ? last_r : rr_pick_s;
`else
    assign rr_req_s    = req;
    assign found_s     = rr_found_s;
    assign pick_s      = rr_pick_s;
    assign next_last_s = rr_pick_s;
`endif

    assign grant_s = found_s & ~downloading & ~loop_rst;

    // Arbitration FSM; every channel output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            gnt_r      <= {IW{1'b0}};
            last_r     <= IW'(N-1);
            sdram_req  <= 1'b0;
            sdram_addr <= {AW{1'b0}};
            ok         <= {N{1'b0}};
            dout       <= {DW{1'b0}};
            busy       <= 1'b0;
            refresh_en <= 1'b1;
        end else begin
            ok <= {N{1'b0}};
            case (state_r)
                S_IDLE: begin
                    if (grant_s) begin
                        gnt_r      <= pick_s;
                        last_r     <= next_last_s;
                        sdram_addr <= addr_a_s[pick_s];
                        sdram_req  <= 1'b1;
                        busy       <= 1'b1;
                        refresh_en <= 1'b0;
                        state_r    <= S_WAIT_ACK;
                    end else begin
                        refresh_en <= 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (data_rdy) begin
                            // Ack and data in one cycle: finish straight away.
                            dout       <= data_read;
                            ok         <= req[gnt_r] ? (ONE_HOT0 << gnt_r) : {N{1'b0}};
                            busy       <= 1'b0;
                            refresh_en <= 1'b1;
                            state_r    <= S_IDLE;
                        end else begin
                            state_r <= S_WAIT_RDY;
                        end
                    end else begin
                        state_r <= S_WAIT_ACK;
                    end
                end
                S_WAIT_RDY: begin
                    if (data_rdy) begin
                        // A requester that gave up still gets dout, but no ok.
                        dout       <= data_read;
                        ok         <= req[gnt_r] ? (ONE_HOT0 << gnt_r) : {N{1'b0}};
                        busy       <= 1'b0;
                        refresh_en <= 1'b1;
                        state_r    <= S_IDLE;
                    end else begin
                        state_r <= S_WAIT_RDY;
                    end
                end
                default: begin
                    sdram_req  <= 1'b0;
                    busy       <= 1'b0;
                    refresh_en <= 1'b1;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Self-checking bench for jtframe_rom_arb: transaction-level model, emulated SDRAM
// controller and directed scenarios.
module tb_jtframe_rom_arb;
    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            downloading;
    logic            loop_rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    ok;
    logic [DW-1:0]   dout;
    logic            busy;
    logic            sdram_req;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_ack = 1'b0;
    logic            data_rdy  = 1'b0;
    logic [DW-1:0]   data_read = 32'h0;
    logic            refresh_en;

    jtframe_rom_arb #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
        .req(req), .addr(addr), .ok(ok), .dout(dout), .busy(busy),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef JTFRAME_ARB_FIXPRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int after_grant(input logic [N-1:0] r, input int last);
`ifdef JTFRAME_ARB_FIXPRIO_EN
        if (r[0]) return last;
`endif
        return pick(r, last);
    endfunction

    logic          m_busy  = 1'b0;
    logic          m_acked = 1'b0;
    int            m_slot  = 0;
    int            m_last  = N-1;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_dout  = '0;
    logic [N-1:0]  m_ok    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_acked <= 1'b0; m_slot <= 0; m_last <= N-1;
            m_addr <= '0;   m_dout  <= '0;   m_ok   <= '0;
        end else begin
            m_ok <= '0;
            if (!m_busy) begin
                if (!downloading && !loop_rst && req != 4'b0000) begin
                    m_busy  <= 1'b1;
                    m_acked <= 1'b0;
                    m_slot  <= pick(req, m_last);
                    m_last  <= after_grant(req, m_last);
                    m_addr  <= addr[pick(req, m_last)*AW +: AW];
                end
            end else if (data_rdy && (m_acked || sdram_ack)) begin
                m_busy <= 1'b0;
                m_dout <= data_read;
                m_ok   <= req[m_slot] ? (4'b0001 << m_slot) : 4'b0000;
            end else if (sdram_ack) begin
                m_acked <= 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("sdram_req",  sdram_req,  m_busy && !m_acked);
            check("sdram_addr", sdram_addr, m_addr);
            check("busy",       busy,       m_busy);
            check("refresh_en", refresh_en, !m_busy);
            check("ok",         ok,         m_ok);
            check("dout",       dout,       m_dout);
            check("ok_onehot0", $onehot0(ok), 1'b1);
        end
    end

    // ok pulse log
    logic [N-1:0] ok_log [$];
    initial begin
        forever begin
            @(negedge clk);
            if (ok != 4'b0000) ok_log.push_back(ok);
        end
    end

    function automatic logic [N-1:0] ok_at(input int i);
        if (i < ok_log.size()) return ok_log[i];
        return 4'bxxxx;
    endfunction

    // ---------------- emulated SDRAM controller ----------------
    int          ack_dly = 1;
    int          rdy_dly = 1;
    logic        stray   = 1'b0;
    logic [31:0] data_tab [16];
    int          ctl_n     = 0;
    int          ctl_phase = 0;
    int          ctl_cnt   = 0;

    initial begin
        forever begin
            @(negedge clk);
            sdram_ack = 1'b0;
            data_rdy  = 1'b0;
            if (!rst_n) begin
                ctl_phase = 0;
                ctl_cnt   = 0;
            end else begin
                if (ctl_phase == 0 && sdram_req) begin
                    ctl_phase = 1;
                    ctl_cnt   = 0;
                end
                if (ctl_phase == 1) begin
                    ctl_cnt++;
                    if (ctl_cnt >= ack_dly) begin
                        sdram_ack = 1'b1;
                        ctl_cnt   = 0;
                        ctl_phase = 2;
                    end
                end else if (ctl_phase == 2) begin
                    ctl_cnt++;
                end else if (stray) begin
                    sdram_ack = 1'b1;
                    data_rdy  = 1'b1;
                    data_read = 32'hBAD0BAD0;
                end
                if (ctl_phase == 2 && ctl_cnt >= rdy_dly) begin
                    data_rdy  = 1'b1;
                    data_read = data_tab[ctl_n % 16];
                    ctl_n++;
                    ctl_phase = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic auto_drop = 1'b1;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (auto_drop) req = req & ~ok;
        end
    endtask

    logic [N-1:0] exp_order [5];
    int base, lat, hi, cyc;
    logic dropped, done1;

    initial begin
        rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0; req = 4'b0000;
        addr = {22'h3FFFFF, 22'h155555, 22'h0ABCDE, 22'h012345};
        for (int i = 0; i < 16; i++) data_tab[i] = 32'h1000_0000 * i + 32'h0123_4567;
`ifdef JTFRAME_ARB_FIXPRIO_EN
        exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        run(3);
        check("rst_sdram_req",  sdram_req,  1'b0);
        check("rst_sdram_addr", sdram_addr, 22'h0);
        check("rst_ok",         ok,         4'b0000);
        check("rst_dout",       dout,       32'h0);
        check("rst_busy",       busy,       1'b0);
        check("rst_refresh",    refresh_en, 1'b1);
        rst_n = 1'b1;
        run(2);

        // Single requester, slow controller
        ack_dly = 2; rdy_dly = 3;
        data_tab[ctl_n % 16] = 32'hDEADBEEF;
        base = ok_log.size();
        req = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            run(1);
            if (sdram_req) check("t1_addr", sdram_addr, 22'h012345);
            if (busy) check("t1_refresh_busy", refresh_en, 1'b0);
        end
        check("t1_ok_count", ok_log.size() - base, 1);
        check("t1_ok", ok_at(base), 4'b0001);
        check("t1_dout", dout, 32'hDEADBEEF);
        check("t1_refresh_after", refresh_en, 1'b1);

        // All four requesting: round-robin order and minimum latency
        ack_dly = 1; rdy_dly = 1; auto_drop = 1'b0;
        rst_n = 1'b0; req = 4'b1111; run(2);
        base = ok_log.size();
        rst_n = 1'b1;
        lat = 0;
        while (ok == 4'b0000 && lat < 20) begin
            run(1);
            lat++;
        end
        check("t2_latency", lat, 3);
        run(13);
        req = 4'b0000; auto_drop = 1'b1;
        run(10);
        for (int i = 0; i < 5; i++) check("t2_order", ok_at(base + i), exp_order[i]);

        // Blocking by downloading / loop_rst, stray controller strobes in IDLE
        rst_n = 1'b0; req = 4'b0000; run(2); rst_n = 1'b1; run(1);
        base = ok_log.size();
        downloading = 1'b1; req = 4'b0110; stray = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                downloading = 1'b0;
                loop_rst = 1'b1;
            end
            run(1);
            check("t3_blocked_req", sdram_req, 1'b0);
            check("t3_blocked_refresh", refresh_en, 1'b1);
        end
        stray = 1'b0;
        run(1);
        check("t3_stray_dout", dout, 32'h0);
        loop_rst = 1'b0;
        run(15);
        check("t3_ok_count", ok_log.size() - base, 2);
        check("t3_first", ok_at(base), 4'b0010);
        check("t3_second", ok_at(base + 1), 4'b0100);

        // req[2] dropped while waiting for data; slot 0 pending meanwhile
        ack_dly = 1; rdy_dly = 4;
        data_tab[ctl_n % 16] = 32'hCAFEF00D;
        data_tab[(ctl_n + 1) % 16] = 32'h600DD00D;
        base = ok_log.size();
        dropped = 1'b0; done1 = 1'b0;
        req = 4'b0100;
        for (int c = 0; c < 30; c++) begin
            run(1);
            if (!dropped && busy && !sdram_req) begin
                req = 4'b0001;
                dropped = 1'b1;
            end else if (dropped && !done1 && !busy) begin
                check("t4_dout_dropped", dout, 32'hCAFEF00D);
                check("t4_ok_suppressed", ok, 4'b0000);
                done1 = 1'b1;
            end
        end
        check("t4_ok_count", ok_log.size() - base, 1);
        check("t4_next_slot", ok_at(base), 4'b0001);
        check("t4_dout_next", dout, 32'h600DD00D);

        // Ack and data in the same cycle
        ack_dly = 1; rdy_dly = 0;
        data_tab[ctl_n % 16] = 32'h5A5AA5A5;
        base = ok_log.size();
        hi = 0;
        req = 4'b1000;
        for (int c = 0; c < 10; c++) begin
            run(1);
            if (sdram_req) hi++;
        end
        check("t5_req_cycles", hi, 1);
        check("t5_ok_count", ok_log.size() - base, 1);
        check("t5_ok", ok_at(base), 4'b1000);
        check("t5_dout", dout, 32'h5A5AA5A5);

        // Asynchronous reset while waiting for ack
        ack_dly = 6; rdy_dly = 1;
        req = 4'b0010;
        cyc = 0;
        while (!sdram_req && cyc < 10) begin
            run(1);
            cyc++;
        end
        check("t6_started", sdram_req, 1'b1);
        run(1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_req", sdram_req, 1'b0);
        check("t6_async_busy", busy, 1'b0);
        check("t6_async_ok", ok, 4'b0000);
        check("t6_async_refresh", refresh_en, 1'b1);
        check("t6_async_addr", sdram_addr, 22'h0);
        @(negedge clk);
        req = 4'b1000; ack_dly = 1;
        run(1);
        base = ok_log.size();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            run(1);
            if (sdram_req) check("t6_addr", sdram_addr, 22'h3FFFFF);
        end
        check("t6_ok_count", ok_log.size() - base, 1);
        check("t6_ok", ok_at(base), 4'b1000);

        run(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_rom_arb.md
Name: jtframe_rom_arb

Overview:
- Shares the single game-side SDRAM read channel among N ROM requesters: CPU, character, object and sound ROM fetchers.
- Channel signals: sdram_req, sdram_addr, sdram_ack, data_rdy, data_read, refresh_en.
- Sits inside the game top, between the per-ROM fetch logic and the frame SDRAM controller.
- Grants one requester at a time, round-robin. Returns the 32-bit word with a one-cycle strobe. Drives refresh_en when the channel is idle.

Parameters:
- N, 4, number of requesters (2..8).
- AW, 22, SDRAM word address width.
- DW, 32, read data width.

Ports:
- clk  in  1  system clock (clk_sys domain).
- rst_n  in  1  asynchronous, active-low reset.
- downloading  in  1  ROM download in progress; blocks new grants.
- loop_rst  in  1  SDRAM init loop active; blocks new grants.
- req  in  N  per-requester read request, level; held until the matching ok.
- addr  in  N*AW  flattened request addresses; slot i is at [i*AW +: AW].
- ok  out  N  one-cycle data-valid strobe, per requester.
- dout  out  DW  last word read, shared by all requesters.
- busy  out  1  transaction in flight.
- sdram_req  out  1  request to the SDRAM controller.
- sdram_addr  out  AW  address to the SDRAM controller.
- sdram_ack  in  1  controller accepted the request.
- data_rdy  in  1  data_read valid this cycle.
- data_read  in  DW  read data from the controller.
- refresh_en  out  1  controller may refresh.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; sdram_req=0; sdram_addr=0; ok=0; dout=0; busy=0; refresh_en=1.
  - last grant pointer = N-1, so slot 0 wins first.
- IDLE:
  - If downloading|loop_rst: no grant; refresh_en=1.
  - Otherwise, pick the first set req bit searching from (last+1) mod N, wrapping.
  - On a grant (clock edge):
    - latch index to gnt and last;
    - sdram_addr <= addr slot gnt;
    - sdram_req <= 1; busy <= 1; refresh_en <= 0;
    - go to WAIT_ACK.
  - With no req set: refresh_en=1.
- WAIT_ACK:
  - Hold sdram_req and sdram_addr stable.
  - On sdram_ack=1: sdram_req <= 0, go to WAIT_RDY.
  - If data_rdy=1 in the same cycle as sdram_ack: complete directly as in WAIT_RDY.
- WAIT_RDY:
  - On data_rdy=1: dout <= data_read; ok[gnt] <= 1 for exactly one cycle; busy <= 0; go to IDLE.
  - A new grant is evaluated on the cycle after ok. No back-to-back grant in the ok cycle.
- Latency:
  - req sampled at edge k gives sdram_req high after edge k.
  - ok rises on the edge after data_rdy is sampled.
  - Minimum req-to-ok: 3 cycles, when the controller acks and returns data in consecutive cycles.
- Dropped request:
  - If req[gnt] falls before completion, the SDRAM transaction still completes and dout updates.
  - ok[gnt] is suppressed (req[gnt] sampled low at data_rdy).
- Blocking:
  - downloading or loop_rst rising mid-transaction does not abort it. It finishes normally, then the block stays in IDLE.
- Round-robin fairness: with all req high, grant order is 0,1,..,N-1,0 and repeats.
- sdram_ack or data_rdy arriving in IDLE is ignored.
- ok is never asserted for more than one bit at a time.
- Reset asserted mid-operation returns every output to its reset value immediately. An outstanding controller transaction is abandoned.

Optional Feature:
- Macro: JTFRAME_ARB_FIXPRIO_EN.
  - Defined: slot 0 (CPU ROM) has fixed top priority. When req[0] is set in IDLE it wins regardless of the pointer. The other slots stay round-robin among themselves.
  - Undefined: pure round-robin across all N slots as above.

Test Plan:
- Single requester: req=0001, addr0=22'h012345; controller acks 2 cycles later and sets data_rdy with data_read=32'hDEADBEEF 3 cycles after that. Expect:
  - sdram_addr=22'h012345 while sdram_req is high;
  - ok=0001 for exactly one cycle;
  - dout=32'hDEADBEEF;
  - refresh_en=0 during the transaction, 1 after.
- All four req high, controller ack+rdy after 1 cycle each. Expect grant order 0,1,2,3,0 and ok one-hot in that sequence.
- downloading=1 with req=0110. Expect:
  - sdram_req stays 0 and refresh_en=1;
  - after downloading falls, slot 1 is granted first.
- req[2] dropped while in WAIT_RDY. Expect dout updated, ok stays 0000, then the next pending slot is granted.
- Same-cycle sdram_ack and data_rdy. Expect a single completion, ok pulses once, sdram_req low the next cycle.
- rst_n pulled low in WAIT_ACK. Expect sdram_req=0, busy=0, ok=0 asynchronously; after release, req=1000 is granted normally.
- With JTFRAME_ARB_FIXPRIO_EN defined and req=1111 continuously: slot 0 is granted on every transaction.
